// File: rtl/serial_write_scheduler.sv
// rtl/serial_write_scheduler.sv - round-robin scheduler sharing one serial write buffer between NUM_REQ requesters
// Optional inter-frame guard gap enabled by defining SERIAL_SCHED_GUARD_EN.
module serial_write_scheduler #(
  parameter int BUF_SIZE = 8,
  parameter int NUM_REQ  = 2,
  parameter int CLK_DIV  = 4
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*BUF_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic                        buf_start,
  output logic                        buf_write_sig,
  output logic [BUF_SIZE-1:0]         buf_data,
  input  logic                        buf_busy,
  output logic                        sched_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACCEPT,
    S_RUN,
    S_FINISH
`ifdef SERIAL_SCHED_GUARD_EN
    , S_GUARD
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 start_q, start_d;
  logic                 wsig_q, wsig_d;
  logic [BUF_SIZE-1:0]  data_q, data_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     idx_q, idx_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 sched_busy_q, sched_busy_d;

  logic                 found;
  logic [PTR_W-1:0]     pick;
  logic [PTR_W-1:0]     cand;

  // Round-robin search: first requesting index starting at the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and registered-output logic for the transfer sequence.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    start_d  = 1'b0;
    wsig_d   = 1'b0;
    data_d   = data_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    div_d    = div_q;
    case (state_q)
      S_IDLE: begin
        // A busy buffer is still resetting or draining; hold off granting.
        if (found && !buf_busy) begin
          grant_d = NUM_REQ'(1) << pick;
          idx_d   = pick;
          data_d  = req_data[pick*BUF_SIZE +: BUF_SIZE];
          start_d = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (buf_busy) begin
          div_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!buf_busy) begin
          done_d  = grant_q;
          state_d = S_FINISH;
        end else begin
          wsig_d = (div_q == DIV_MAX);
          div_d  = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        end
      end
      S_FINISH: begin
        grant_d = '0;
        ptr_d   = (idx_q == LAST_REQ) ? '0 : idx_q + 1'b1;
`ifdef SERIAL_SCHED_GUARD_EN
        div_d   = '0;
        state_d = S_GUARD;
`else
        state_d = S_IDLE;
`endif
      end
`ifdef SERIAL_SCHED_GUARD_EN
      S_GUARD: begin
        // Quiet line for CLK_DIV cycles before the next frame may start.
        if (div_q == DIV_MAX) begin
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
    sched_busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset that aborts any transfer.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      start_q      <= 1'b0;
      wsig_q       <= 1'b0;
      data_q       <= '0;
      ptr_q        <= '0;
      idx_q        <= '0;
      div_q        <= '0;
      sched_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      start_q      <= start_d;
      wsig_q       <= wsig_d;
      data_q       <= data_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      div_q        <= div_d;
      sched_busy_q <= sched_busy_d;
    end
  end

  assign grant         = grant_q;
  assign done          = done_q;
  assign buf_start     = start_q;
  assign buf_write_sig = wsig_q;
  assign buf_data      = data_q;
  assign sched_busy    = sched_busy_q;

endmodule

// File: tb/tb_serial_write_scheduler.sv
// tb/tb_serial_write_scheduler.sv - randomized scoreboard bench for serial_write_scheduler
module tb_serial_write_scheduler;

  localparam int BUF_SIZE = 8;
  localparam int NUM_REQ  = 2;
  localparam int CLK_DIV  = 4;
`ifdef SERIAL_SCHED_GUARD_EN
  localparam int GUARD_CYC = CLK_DIV;
`else
  localparam int GUARD_CYC = 0;
`endif
  // done cycle to next buf_start cycle: FINISH, optional guard, one IDLE cycle
  localparam int MIN_GAP = GUARD_CYC + 2;

  logic                        sys_clk = 1'b0;
  logic                        rst;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*BUF_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]          grant;
  logic [NUM_REQ-1:0]          done;
  logic                        buf_start;
  logic                        buf_write_sig;
  logic [BUF_SIZE-1:0]         buf_data;
  logic                        buf_busy;
  logic                        sched_busy;

  serial_write_scheduler #(.BUF_SIZE(BUF_SIZE), .NUM_REQ(NUM_REQ), .CLK_DIV(CLK_DIV)) dut (
    .sys_clk(sys_clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .buf_start(buf_start), .buf_write_sig(buf_write_sig),
    .buf_data(buf_data), .buf_busy(buf_busy), .sched_busy(sched_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural serial write buffer: loads on start, busy until BUF_SIZE strobes shift MSB first.
  logic                mdl_busy;
  logic                force_busy;
  logic [BUF_SIZE-1:0] mdl_sh;
  int                  mdl_cnt;
  assign buf_busy = mdl_busy | force_busy;

  always @(posedge sys_clk) begin
    if (rst) begin
      mdl_busy <= 1'b0;
      mdl_sh   <= '0;
      mdl_cnt  <= 0;
    end else if (buf_start) begin
      mdl_sh   <= buf_data;
      mdl_cnt  <= 0;
      mdl_busy <= 1'b1;
    end else if (buf_write_sig && mdl_busy) begin
      mdl_sh  <= mdl_sh << 1;
      mdl_cnt <= mdl_cnt + 1;
      if (mdl_cnt == BUF_SIZE - 1) mdl_busy <= 1'b0;
    end
  end

  int cyc = 0;
  bit rst_at_edge = 1'b0;
  always @(posedge sys_clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  typedef struct {
    int                  idx;
    logic [BUF_SIZE-1:0] word;
  } exp_t;
  exp_t exp_q[$];

  // Monitor state
  bit                  mon_en = 1'b0;
  bit                  inflight = 1'b0;
  bit                  prev_start = 1'b0;
  bit                  prev_busy = 1'b0;
  int                  last_done_cyc = -1000;
  int                  busy_rise = -1;
  int                  last_strobe = 0;
  int                  n_strobes = 0;
  int                  mon_d;
  logic [NUM_REQ-1:0]  cur_grant;
  logic [NUM_REQ-1:0]  exp_grant;
  logic [BUF_SIZE-1:0] cur_word;
  logic [BUF_SIZE-1:0] bits;
  exp_t                e;

  // Monitor: follows each frame from buf_start to done and scores it against the expected queue.
  always @(negedge sys_clk) begin
    if (rst_at_edge) begin
      inflight      = 1'b0;
      prev_start    = 1'b0;
      last_done_cyc = -1000;
      n_strobes     = 0;
    end else if (mon_en) begin
      mon_d = cyc - last_done_cyc;
      chk($countones(grant) <= 1, "grant_onehot", $countones(grant), 1);
      chk($countones(done) <= 1, "done_onehot", $countones(done), 1);
      if (buf_start) begin
        chk(!prev_start, "start_one_cycle", prev_start, 0);
        chk(!inflight, "start_no_overlap", inflight, 0);
        chk(mon_d >= MIN_GAP, "done_to_start_gap", mon_d, MIN_GAP);
        chk($countones(grant) == 1, "grant_at_start", grant, 1);
        chk(sched_busy, "busy_at_start", sched_busy, 1);
        inflight  = 1'b1;
        cur_grant = grant;
        cur_word  = buf_data;
        n_strobes = 0;
        bits      = '0;
        busy_rise = -1;
      end else if (inflight) begin
        chk(grant == cur_grant, "grant_stable", grant, cur_grant);
        chk(buf_data == cur_word, "data_stable", buf_data, cur_word);
        chk(sched_busy, "busy_in_frame", sched_busy, 1);
      end
      if (inflight && buf_busy && !prev_busy && busy_rise < 0) busy_rise = cyc;
      if (buf_write_sig) begin
        chk(inflight, "strobe_in_frame", inflight, 1);
        // busy is first seen in ACCEPT, RUN starts the edge after, strobe CLK_DIV edges later
        if (n_strobes == 0) chk(cyc - busy_rise == CLK_DIV + 1, "first_strobe_delay", cyc - busy_rise, CLK_DIV + 1);
        else chk(cyc - last_strobe == CLK_DIV, "strobe_spacing", cyc - last_strobe, CLK_DIV);
        bits        = {bits[BUF_SIZE-2:0], mdl_sh[BUF_SIZE-1]};
        n_strobes++;
        last_strobe = cyc;
      end
      if (done != '0) begin
        chk(inflight, "done_in_frame", inflight, 1);
        chk(done == cur_grant && grant == cur_grant, "done_matches_grant", done, cur_grant);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          exp_grant = NUM_REQ'(1) << e.idx;
          chk(cur_grant == exp_grant, "service_order", cur_grant, exp_grant);
          chk(cur_word == e.word, "frame_word", cur_word, e.word);
          chk(bits == e.word, "line_bits", bits, e.word);
          chk(n_strobes == BUF_SIZE, "strobe_count", n_strobes, BUF_SIZE);
        end
        last_done_cyc = cyc;
        inflight      = 1'b0;
      end else if (!inflight) begin
        chk(sched_busy == (mon_d >= 1 && mon_d <= GUARD_CYC), "sched_busy_between_frames",
            sched_busy, (mon_d >= 1 && mon_d <= GUARD_CYC));
      end
      prev_start = buf_start;
      prev_busy  = buf_busy;
    end
  end

  // Reference model: requesters served in circular order starting at the pointer,
  // each pending request consuming one frame; pointer moves past the one served.
  int model_ptr = 0;
  int rem[NUM_REQ];

  task automatic model_push(input logic [NUM_REQ-1:0] set, input int cnt,
                            input logic [NUM_REQ*BUF_SIZE-1:0] words);
    int   r[NUM_REQ];
    int   left;
    exp_t x;
    left = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r[i] = set[i] ? cnt : 0;
      left += r[i];
    end
    while (left > 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (model_ptr + k) % NUM_REQ;
        if (r[j] > 0) begin
          x.idx  = j;
          x.word = words[j*BUF_SIZE +: BUF_SIZE];
          exp_q.push_back(x);
          r[j]--;
          left--;
          model_ptr = (j + 1) % NUM_REQ;
          break;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(grant == '0, {tag, "_grant"}, grant, 0);
    chk(done == '0, {tag, "_done"}, done, 0);
    chk(buf_start == 1'b0, {tag, "_buf_start"}, buf_start, 0);
    chk(buf_write_sig == 1'b0, {tag, "_write_sig"}, buf_write_sig, 0);
    chk(buf_data == '0, {tag, "_buf_data"}, buf_data, 0);
    chk(sched_busy == 1'b0, {tag, "_sched_busy"}, sched_busy, 0);
  endtask

  // One batch: each requester in set asks for cnt frames, optionally with the buffer held busy first.
  task automatic run_phase(input logic [NUM_REQ-1:0] set, input int cnt, input int hold,
                           input logic [NUM_REQ*BUF_SIZE-1:0] words);
    int  guard;
    bit  pending;
    logic [NUM_REQ-1:0] first;
    req_data = words;
    model_push(set, cnt, words);
    first = NUM_REQ'(1) << exp_q[0].idx;
    for (int i = 0; i < NUM_REQ; i++) rem[i] = set[i] ? cnt : 0;
    if (hold > 0) force_busy = 1'b1;
    req = set;
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge sys_clk);
        chk(grant == '0 && !buf_start, "no_grant_while_busy", grant, 0);
      end
      force_busy = 1'b0;
      @(negedge sys_clk);
      chk(grant == first && buf_start, "grant_after_busy_falls", grant, first);
    end
    guard   = 0;
    pending = 1'b1;
    while (pending && guard < 120 * cnt * NUM_REQ + 50) begin
      @(negedge sys_clk);
      guard++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done[i] && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) req[i] = 1'b0;
        end else if (grant[i] && rem[i] == 1 && req[i] && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      pending = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) if (rem[i] > 0) pending = 1'b1;
    end
    chk(!pending, "phase_timeout", guard, 0);
    repeat (3) @(negedge sys_clk);
    chk(exp_q.size() == 0, "all_frames_served", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Abort a frame from requester 1 after its third strobe; it must never report done.
  task automatic reset_mid_frame();
    int guard;
    req_data[BUF_SIZE +: BUF_SIZE] = BUF_SIZE'($urandom);
    req   = 2'b10;
    guard = 0;
    while (!(inflight && n_strobes >= 3) && guard < 200) begin
      @(negedge sys_clk);
      guard++;
    end
    chk(inflight && n_strobes >= 3, "reach_third_strobe", n_strobes, 3);
    rst = 1'b1;
    req = '0;
    @(negedge sys_clk);
    check_reset_outputs("mid_reset");
    rst       = 1'b0;
    model_ptr = 0;
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    req_data   = '0;
    force_busy = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge sys_clk);

    run_phase(2'b01, 1, 0, {8'h00, 8'hA5});
    run_phase(2'b11, 2, 0, {8'hC3, 8'h3C});
    run_phase(2'b10, 1, 6, {8'h96, 8'h00});
    run_phase(2'b01, 1, 0, {8'h00, 8'h5A});
    reset_mid_frame();
    run_phase(2'b11, 1, 0, {8'h81, 8'h7E});
    for (int n = 0; n < 12; n++) begin
      run_phase(NUM_REQ'($urandom_range(1, 3)), $urandom_range(1, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                (NUM_REQ*BUF_SIZE)'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d expected 0", cyc);
    $fatal(1);
  end

endmodule
